// File: rtl/tcp_arb_pkg.sv
// Shared types and helpers for the TCP connection arbiter.
// Command/state encodings plus req_cmd slicing.
package tcp_arb_pkg;

  typedef enum logic [1:0] {
    ACTIVE_OPEN  = 2'd0,
    PASSIVE_OPEN = 2'd1,
    SEND         = 2'd2,
    CLOSE        = 2'd3
  } tcp_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int MAX_REQ = 32;

  function automatic tcp_cmd_e cmd_at(
    input logic [2*MAX_REQ-1:0] v,
    input int                   i
  );
    return tcp_cmd_e'(v[2*i +: 2]);
  endfunction

  function automatic logic is_open(input tcp_cmd_e c);
    return (c == ACTIVE_OPEN) || (c == PASSIVE_OPEN);
  endfunction

endpackage

// File: rtl/tcp_conn_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or
// after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin : pick
    int k;
    k       = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      if (!found_o && req_i[k]) begin
        found_o = 1'b1;
        idx_o   = W'(k);
      end
    end
  end

endmodule

// File: rtl/tcp_conn_arbiter.sv
// Shares one TCP FSM among N_REQ requesters; owner lock + timeout.
// Optional stats counters under `TCP_ARB_STATS_EN.
module tcp_conn_arbiter
  import tcp_arb_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int TIMEOUT_CYC = 1000,
  localparam int ID_W        = $clog2(N_REQ),
  localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [2*N_REQ-1:0] req_cmd,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   req_nack,
  output logic               owner_vld,
  output logic [ID_W-1:0]    owner_id,
  input  logic               ACK_i,
  input  logic               FIN_i,
  input  logic               RST_i,
  input  logic               SYN_i,
  output logic               a_opn,
  output logic               p_opn,
  output logic               send_data,
  output logic               cls,
  output logic               timo_strb
`ifdef TCP_ARB_STATS_EN
  ,
  output logic [15:0]        stat_grants,
  output logic [15:0]        stat_timeouts
`endif
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    own_q, own_d;
  logic               vld_q, vld_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   nack_q, nack_d;
  logic               aop_q, aop_d;
  logic               pop_q, pop_d;
  logic               snd_q, snd_d;
  logic               cls_q, cls_d;
  logic               tmo_q, tmo_d;

  logic [2*MAX_REQ-1:0] cmd_ext;
  tcp_cmd_e             cmd [N_REQ];
  logic [N_REQ-1:0]     live;
  logic [N_REQ-1:0]     open_req;
  logic [ID_W-1:0]      win;
  logic                 found;
  logic                 peer;

  // A request just acked/nacked is still held this cycle; mask it
  assign live = req_valid & ~(ack_q | nack_q);
  assign peer = ACK_i | FIN_i | RST_i | SYN_i;

  always_comb begin
    cmd_ext              = '0;
    cmd_ext[2*N_REQ-1:0] = req_cmd;
    for (int i = 0; i < N_REQ; i++) begin
      cmd[i]      = cmd_at(cmd_ext, i);
      open_req[i] = live[i] & is_open(cmd[i]);
    end
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req_i   (open_req),
    .ptr_i   (ptr_q),
    .idx_o   (win),
    .found_o (found)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    vld_d   = vld_q;
    tmr_d   = tmr_q;
    ack_d   = '0;
    nack_d  = '0;
    aop_d   = 1'b0;
    pop_d   = 1'b0;
    snd_d   = 1'b0;
    cls_d   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        nack_d = live & ~open_req;
        if (found) begin
          ack_d[win] = 1'b1;
          aop_d      = (cmd[win] == ACTIVE_OPEN);
          pop_d      = (cmd[win] == PASSIVE_OPEN);
          own_d      = win;
          vld_d      = 1'b1;
          ptr_d      = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
          tmr_d      = '0;
          state_d    = OWNED;
        end
      end
      OWNED: begin
        tmr_d = tmr_q + CNT_W'(1);
        // Owner activity beats expiry, so CLOSE suppresses timo_strb
        if (live[own_q]) begin
          tmr_d = '0;
          case (cmd[own_q])
            SEND: begin
              ack_d[own_q] = 1'b1;
              snd_d        = 1'b1;
            end
            CLOSE: begin
              ack_d[own_q] = 1'b1;
              cls_d        = 1'b1;
              state_d      = DRAIN;
            end
            default: nack_d[own_q] = 1'b1;
          endcase
        end else if (peer) begin
          tmr_d = '0;
        end else if (tmr_q == TERM) begin
          tmo_d   = 1'b1;
          tmr_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        tmr_d = tmr_q + CNT_W'(1);
        if (live[own_q]) nack_d[own_q] = 1'b1;
        if (tmr_q == TERM) begin
          tmo_d   = 1'b1;
          vld_d   = 1'b0;
          tmr_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      vld_q   <= 1'b0;
      tmr_q   <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      aop_q   <= 1'b0;
      pop_q   <= 1'b0;
      snd_q   <= 1'b0;
      cls_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      vld_q   <= vld_d;
      tmr_q   <= tmr_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      aop_q   <= aop_d;
      pop_q   <= pop_d;
      snd_q   <= snd_d;
      cls_q   <= cls_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_nack  = nack_q;
  assign owner_vld = vld_q;
  assign owner_id  = own_q;
  assign a_opn     = aop_q;
  assign p_opn     = pop_q;
  assign send_data = snd_q;
  assign cls       = cls_q;
  assign timo_strb = tmo_q;

`ifdef TCP_ARB_STATS_EN
  logic [15:0] grants_q;
  logic [15:0] touts_q;
  logic        grant_ev;
  logic        tout_ev;

  // Timeout while still owned is the only strobe with owner_vld high
  assign grant_ev = aop_q | pop_q;
  assign tout_ev  = tmo_q & vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants_q <= '0;
      touts_q  <= '0;
    end else begin
      if (grant_ev && (grants_q != 16'hFFFF)) grants_q <= grants_q + 16'd1;
      if (tout_ev && (touts_q != 16'hFFFF)) touts_q <= touts_q + 16'd1;
    end
  end

  assign stat_grants   = grants_q;
  assign stat_timeouts = touts_q;
`endif

endmodule

// File: tb/tb_tcp_conn_arbiter.sv
// Scoreboard bench for tcp_conn_arbiter, N_REQ=4, TIMEOUT_CYC=10.
// Expected output words are queued per cycle and popped on compare.
module tb_tcp_conn_arbiter;

  localparam int N  = 4;
  localparam int TO = 10;

  localparam logic [1:0] C_AOPEN = 2'd0;
  localparam logic [1:0] C_POPEN = 2'd1;
  localparam logic [1:0] C_SEND  = 2'd2;
  localparam logic [1:0] C_CLOSE = 2'd3;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_A    = 5'b10000;
  localparam logic [4:0] P_P    = 5'b01000;
  localparam logic [4:0] P_S    = 5'b00100;
  localparam logic [4:0] P_C    = 5'b00010;
  localparam logic [4:0] P_T    = 5'b00001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [2*N-1:0] req_cmd;
  logic [N-1:0] req_ack;
  logic [N-1:0] req_nack;
  logic         owner_vld;
  logic [1:0]   owner_id;
  logic         ACK_i, FIN_i, RST_i, SYN_i;
  logic         a_opn, p_opn, send_data, cls, timo_strb;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got;
  logic [15:0] want;

  always #5 clk = ~clk;

  tcp_conn_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ack   (req_ack),
    .req_nack  (req_nack),
    .owner_vld (owner_vld),
    .owner_id  (owner_id),
    .ACK_i     (ACK_i),
    .FIN_i     (FIN_i),
    .RST_i     (RST_i),
    .SYN_i     (SYN_i),
    .a_opn     (a_opn),
    .p_opn     (p_opn),
    .send_data (send_data),
    .cls       (cls),
    .timo_strb (timo_strb)
  );

  function automatic logic [15:0] mk(
    input logic [3:0] ack,
    input logic [3:0] nack,
    input logic [4:0] pul,
    input logic       v,
    input logic [1:0] id
  );
    return {ack, nack, pul, v, id};
  endfunction

  function automatic logic [15:0] obs();
    return {req_ack, req_nack, a_opn, p_opn, send_data,
            cls, timo_strb, owner_vld, owner_id};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] c);
    req_valid[i]      = v;
    req_cmd[2*i +: 2] = c;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    {ACK_i, FIN_i, RST_i, SYN_i} = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(16'h0000);
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", got, want);
    end
    rst_n = 1'b1;
    exp_q.push_back(16'h0000);
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL idle_quiet got=%h want=%h", got, want);
    end
  endtask

  task automatic test_open_arb();
    set_req(1, 1'b1, C_AOPEN);
    set_req(3, 1'b1, C_POPEN);
    exp_q.push_back(mk(4'b0010, 4'b0000, P_A, 1'b1, 2'd1));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL open_grant got=%h want=%h", got, want);
    end
    set_req(1, 1'b0, C_AOPEN);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b1, 2'd1));
      cyc();
      want = exp_q.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL nonowner_held k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_send_close();
    set_req(1, 1'b1, C_SEND);
    exp_q.push_back(mk(4'b0010, 4'b0, P_S, 1'b1, 2'd1));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL send got=%h want=%h", got, want);
    end
    set_req(1, 1'b0, C_SEND);
    exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b1, 2'd1));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL post_send got=%h want=%h", got, want);
    end
    set_req(1, 1'b1, C_CLOSE);
    exp_q.push_back(mk(4'b0010, 4'b0, P_C, 1'b1, 2'd1));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL close got=%h want=%h", got, want);
    end
    set_req(1, 1'b0, C_CLOSE);
    for (int k = 1; k <= TO; k++) begin
      if (k == 2) set_req(1, 1'b1, C_SEND);
      if (k == 3) set_req(1, 1'b0, C_SEND);
      if (k == TO)
        exp_q.push_back(mk(4'b0, 4'b0, P_T, 1'b0, 2'd1));
      else if (k == 2)
        exp_q.push_back(mk(4'b0, 4'b0010, P_NONE, 1'b1, 2'd1));
      else
        exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b1, 2'd1));
      cyc();
      want = exp_q.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL drain_after_close k=%0d got=%h want=%h", k, got, want);
      end
    end
    exp_q.push_back(mk(4'b1000, 4'b0, P_P, 1'b1, 2'd3));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL held_grant got=%h want=%h", got, want);
    end
    set_req(3, 1'b0, C_POPEN);
  endtask

  task automatic test_idle_timeout();
    for (int k = 1; k <= 2*TO; k++) begin
      if (k == TO)
        exp_q.push_back(mk(4'b0, 4'b0, P_T, 1'b1, 2'd3));
      else if (k == 2*TO)
        exp_q.push_back(mk(4'b0, 4'b0, P_T, 1'b0, 2'd3));
      else
        exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b1, 2'd3));
      cyc();
      want = exp_q.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL idle_timeout k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_peer_keepalive();
    set_req(2, 1'b1, C_AOPEN);
    exp_q.push_back(mk(4'b0100, 4'b0, P_A, 1'b1, 2'd2));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL grant_rr got=%h want=%h", got, want);
    end
    set_req(2, 1'b0, C_AOPEN);
    for (int k = 1; k <= 40; k++) begin
      ACK_i = (k % 8 == 0);
      exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b1, 2'd2));
      cyc();
      want = exp_q.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL keepalive k=%0d got=%h want=%h", k, got, want);
      end
    end
    ACK_i = 1'b0;
  endtask

  task automatic test_close_vs_timeout();
    for (int k = 41; k <= 50; k++) begin
      if (k == 50) begin
        set_req(2, 1'b1, C_CLOSE);
        exp_q.push_back(mk(4'b0100, 4'b0, P_C, 1'b1, 2'd2));
      end else begin
        exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b1, 2'd2));
      end
      cyc();
      want = exp_q.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL close_vs_expiry k=%0d got=%h want=%h", k, got, want);
      end
    end
    set_req(2, 1'b0, C_CLOSE);
    for (int k = 1; k <= TO; k++) begin
      if (k == TO)
        exp_q.push_back(mk(4'b0, 4'b0, P_T, 1'b0, 2'd2));
      else
        exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b1, 2'd2));
      cyc();
      want = exp_q.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL drain2 k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_idle_nack();
    set_req(0, 1'b1, C_SEND);
    exp_q.push_back(mk(4'b0, 4'b0001, P_NONE, 1'b0, 2'd2));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL idle_nack got=%h want=%h", got, want);
    end
    set_req(0, 1'b0, C_SEND);
    exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b0, 2'd2));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL idle_after_nack got=%h want=%h", got, want);
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, C_AOPEN);
    exp_q.push_back(mk(4'b0001, 4'b0, P_A, 1'b1, 2'd0));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL wrap_grant got=%h want=%h", got, want);
    end
    set_req(0, 1'b0, C_AOPEN);
    exp_q.push_back(mk(4'b0, 4'b0, P_NONE, 1'b1, 2'd0));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL owned_pre_reset got=%h want=%h", got, want);
    end
    rst_n = 1'b0;
    #1;
    exp_q.push_back(16'h0000);
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", got, want);
    end
    set_req(0, 1'b1, C_AOPEN);
    set_req(2, 1'b1, C_POPEN);
    cyc();
    rst_n = 1'b1;
    exp_q.push_back(mk(4'b0001, 4'b0, P_A, 1'b1, 2'd0));
    cyc();
    want = exp_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL ptr_after_reset got=%h want=%h", got, want);
    end
    set_req(0, 1'b0, C_AOPEN);
    set_req(2, 1'b0, C_POPEN);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_open_arb();
    test_send_close();
    test_idle_timeout();
    test_peer_keepalive();
    test_close_vs_timeout();
    test_idle_nack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
